// File: rtl/writeback_stage.sv
// MEM/WB pipeline register, load alignment/extension and write-back select.
// Drives the register-file write port and counts retired instructions.
module writeback_stage #(
  parameter logic [31:0] RESET_COUNT = 32'h0
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        Mem_Valid,
  input  logic        Mem_Reg_Write,
  input  logic [1:0]  Mem_Mem_To_Reg,
  input  logic [2:0]  Mem_Load_Type,
  input  logic [4:0]  Mem_Write_Reg,
  input  logic [31:0] Mem_ALU_Result,
  input  logic [31:0] Mem_Read_Data,
  input  logic [31:0] Mem_PC_Plus_8,
  output logic        Register_Write,
  output logic [4:0]  Write_Reg,
  output logic [31:0] Register_Write_Data,
  output logic        WB_Valid,
  output logic        Load_Fault,
  output logic [31:0] Retired_Count
);

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic [1:0]  mem_to_reg;
    logic [2:0]  load_type;
    logic [4:0]  write_reg;
    logic [31:0] alu_result;
    logic [31:0] read_data;
    logic [31:0] pc_plus_8;
  } mem_wb_t;

  mem_wb_t q;
  mem_wb_t d;

  always_comb begin
    d = q;
    if (Flush) begin
      d = '0;
    end else if (!Stall) begin
      d.valid      = Mem_Valid;
      d.reg_write  = Mem_Reg_Write;
      d.mem_to_reg = Mem_Mem_To_Reg;
      d.load_type  = Mem_Load_Type;
      d.write_reg  = Mem_Write_Reg;
      d.alu_result = Mem_ALU_Result;
      d.read_data  = Mem_Read_Data;
      d.pc_plus_8  = Mem_PC_Plus_8;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) q <= '0;
    else          q <= d;
  end

  logic [1:0]  k;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        is_lh;
  logic        is_lhu;
  logic        is_lb;
  logic        is_lbu;
  logic        is_lw;
  logic        misaligned;
  logic [31:0] load_data;

  assign k        = q.alu_result[1:0];
  assign half_sel = k[1] ? q.read_data[31:16] : q.read_data[15:0];
  assign is_lh    = (q.load_type == 3'b001);
  assign is_lhu   = (q.load_type == 3'b010);
  assign is_lb    = (q.load_type == 3'b011);
  assign is_lbu   = (q.load_type == 3'b100);
  assign is_lw    = !(is_lh | is_lhu | is_lb | is_lbu);

  always_comb begin
    byte_sel = q.read_data[7:0];
    unique case (k)
      2'd0: byte_sel = q.read_data[7:0];
      2'd1: byte_sel = q.read_data[15:8];
      2'd2: byte_sel = q.read_data[23:16];
      2'd3: byte_sel = q.read_data[31:24];
    endcase
  end

  always_comb begin
    load_data = q.read_data;
    unique case (1'b1)
      is_lh:   load_data = {{16{half_sel[15]}}, half_sel};
      is_lhu:  load_data = {16'h0, half_sel};
      is_lb:   load_data = {{24{byte_sel[7]}}, byte_sel};
      is_lbu:  load_data = {24'h0, byte_sel};
      default: load_data = q.read_data;
    endcase
  end

  assign misaligned = (is_lw & (k != 2'd0))
                    | ((is_lh | is_lhu) & k[0]);

  assign Load_Fault = q.valid
                    & (q.mem_to_reg == 2'b01)
                    & misaligned;

  always_comb begin
    Register_Write_Data = q.alu_result;
    unique case (q.mem_to_reg)
      2'b01:   Register_Write_Data = load_data;
      2'b10:   Register_Write_Data = q.pc_plus_8;
      default: Register_Write_Data = q.alu_result;
    endcase
  end

  assign Register_Write = q.valid & q.reg_write
                        & (q.write_reg != 5'd0)
                        & !Load_Fault & !Stall;
  assign Write_Reg = q.write_reg;
  assign WB_Valid  = q.valid;

  logic retire;
  assign retire = q.valid & !Stall & !Load_Fault;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)    Retired_Count <= RESET_COUNT;
    else if (retire) Retired_Count <= Retired_Count + 32'd1;
  end

endmodule
